// File: rtl/keccak_pkg.sv
`default_nettype none
// ============================================================================
// Module  : keccak_pkg
// Purpose : Constants and types shared by the Keccak lane serializer and
//           the lane collector (keccak_lane_sipo).
// Contents: LANE_W, LANES, STATE_W, the collector state enum, and the lane
//           count type.
// Revision: 1.0 - initial release
// ============================================================================
package keccak_pkg;

  localparam int LANE_W  = 64;
  localparam int LANES   = 25;
  localparam int STATE_W = LANE_W * LANES;

  // COLLECT: accepting lanes; FULL: holding a complete state for the consumer
  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } sipo_state_e;

  // Holds 0..25 inclusive
  typedef logic [4:0] lane_cnt_t;

endpackage
`default_nettype wire

// File: rtl/keccak_lane_sipo.sv
`default_nettype none
// ============================================================================
// Module  : keccak_lane_sipo
// Purpose : Collects a 1600-bit Keccak state from 25 serial 64-bit lanes
//           (most-significant lane first) and presents it as one parallel
//           word with its own valid/ready handshake.
// Ports   : clk, rst_n      - clock, asynchronous active-low reset
//           clear           - synchronous abort, drops partial/held state
//           lane_in/_valid  - incoming lane and its qualifier
//           lane_ready      - lane can be accepted this cycle
//           state_out       - assembled state, straight from shift register
//           state_valid     - state_out holds a complete state
//           state_ready     - consumer takes state_out
//           lane_count      - lanes captured in the current state (0..25)
// Revision: 1.0 - initial release
// ============================================================================
import keccak_pkg::*;

module keccak_lane_sipo #(
  parameter int LANE_W  = keccak_pkg::LANE_W,
  parameter int LANES   = keccak_pkg::LANES,
  parameter int STATE_W = LANE_W * LANES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic [LANE_W-1:0]  lane_in,
  input  logic               lane_valid,
  output logic               lane_ready,
  output logic [STATE_W-1:0] state_out,
  input  logic               state_ready,
  output logic               state_valid,
  output logic [4:0]         lane_count
);

  localparam lane_cnt_t LAST_LANE = lane_cnt_t'(LANES - 1);

  sipo_state_e        state_r, state_nxt;
  lane_cnt_t          cnt_r, cnt_nxt;
  logic [STATE_W-1:0] sr_r, sr_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= COLLECT;
      cnt_r   <= '0;
      sr_r    <= '0;
    end else begin
      state_r <= state_nxt;
      cnt_r   <= cnt_nxt;
      sr_r    <= sr_nxt;
    end
  end

  always_comb begin
    state_nxt = state_r;
    cnt_nxt   = cnt_r;
    sr_nxt    = sr_r;
    if (clear) begin
      // Abort wins over any handshake in flight, including a lane offered now
      state_nxt = COLLECT;
      cnt_nxt   = '0;
      sr_nxt    = '0;
    end else begin
      unique case (state_r)
        COLLECT: begin
          if (lane_valid) begin
            // Shift toward the MSB so the first lane ends up on top
            sr_nxt  = {sr_r[STATE_W-LANE_W-1:0], lane_in};
            cnt_nxt = cnt_r + 5'd1;
            if (cnt_r == LAST_LANE) begin
              state_nxt = FULL;
            end
          end
        end
        FULL: begin
          // Register contents are left as-is; the next fill overwrites them
          if (state_ready) begin
            state_nxt = COLLECT;
            cnt_nxt   = '0;
          end
        end
        default: begin
          state_nxt = COLLECT;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Handshake outputs depend on the state register only
  assign lane_ready  = (state_r == COLLECT);
  assign state_valid = (state_r == FULL);
  assign state_out   = sr_r;
  assign lane_count  = cnt_r;

endmodule
`default_nettype wire

// File: tb/tb_keccak_lane_sipo.sv
`default_nettype none
// ============================================================================
// Module  : tb_keccak_lane_sipo
// Purpose : Directed self-checking bench for keccak_lane_sipo: reset values,
//           basic fill, backpressure, gapped input, clear mid-collect, reset
//           mid-collect and back-to-back states.
// Revision: 1.0 - initial release
// ============================================================================
module tb_keccak_lane_sipo;

  localparam int LANE_W  = 64;
  localparam int LANES   = 25;
  localparam int STATE_W = LANE_W * LANES;

  logic               clk;
  logic               rst_n;
  logic               clear;
  logic [LANE_W-1:0]  lane_in;
  logic               lane_valid;
  logic               lane_ready;
  logic [STATE_W-1:0] state_out;
  logic               state_ready;
  logic               state_valid;
  logic [4:0]         lane_count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  keccak_lane_sipo dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .lane_in     (lane_in),
    .lane_valid  (lane_valid),
    .lane_ready  (lane_ready),
    .state_out   (state_out),
    .state_ready (state_ready),
    .state_valid (state_valid),
    .lane_count  (lane_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Lane k (k=0 is the first lane received, at the top) must equal base+k*step
  task automatic check_lanes(input string tag, input logic [63:0] base, input logic [63:0] step);
    logic [63:0] exp;
    for (int k = 0; k < LANES; k++) begin
      exp = base + step * 64'(k);
      check($sformatf("%s[%0d]", tag, k), state_out[STATE_W-1-LANE_W*k -: LANE_W], exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [63:0] base, input logic [63:0] step);
    for (int i = 0; i < LANES; i++) begin
      lane_valid = 1'b1;
      lane_in    = base + step * 64'(i);
      tick();
    end
    lane_valid = 1'b0;
  endtask

  task automatic release_state();
    state_ready = 1'b1;
    tick();
    state_ready = 1'b0;
  endtask

  int          first_valid_cyc;
  int          second_valid_cyc;
  int          n_valid;
  int          idx;
  logic [63:0] sent;
  logic        rdy_before;

  initial begin
    rst_n       = 1'b0;
    clear       = 1'b0;
    lane_in     = '0;
    lane_valid  = 1'b0;
    state_ready = 1'b0;
    tick();
    tick();

    // Reset values
    check("rst_lane_ready",  64'(lane_ready),  64'd1);
    check("rst_state_valid", 64'(state_valid), 64'd0);
    check("rst_lane_count",  64'(lane_count),  64'd0);
    check("rst_state_zero",  64'(|state_out),  64'd0);
    rst_n = 1'b1;
    tick();

    // Basic fill: lanes 1..25 on consecutive cycles
    for (int i = 0; i < LANES; i++) begin
      lane_valid = 1'b1;
      lane_in    = 64'(i + 1);
      tick();
      if (i == 23) begin
        check("fill_valid_pre", 64'(state_valid), 64'd0);
        check("fill_count_24",  64'(lane_count),  64'd24);
      end
    end
    lane_valid = 1'b0;
    check("fill_valid",  64'(state_valid), 64'd1);
    check("fill_ready",  64'(lane_ready),  64'd0);
    check("fill_count",  64'(lane_count),  64'd25);
    check("fill_top",    state_out[1599:1536], 64'd1);
    check("fill_bottom", state_out[63:0],      64'd25);

    // Backpressure: offered lanes in FULL are ignored
    lane_valid = 1'b1;
    lane_in    = 64'hDEAD;
    for (int i = 0; i < 5; i++) tick();
    check_lanes("bp", 64'd1, 64'd1);
    check("bp_count", 64'(lane_count),  64'd25);
    check("bp_valid", 64'(state_valid), 64'd1);
    lane_valid  = 1'b0;
    state_ready = 1'b1;
    tick();
    state_ready = 1'b0;
    check("bp_rel_valid", 64'(state_valid), 64'd0);
    check("bp_rel_count", 64'(lane_count),  64'd0);
    check("bp_rel_ready", 64'(lane_ready),  64'd1);

    // Gaps: valid toggles 1/0, filler data on idle cycles must be ignored
    for (int c = 0; c < 49; c++) begin
      lane_valid = (c % 2 == 0);
      lane_in    = (c % 2 == 0) ? 64'(c / 2 + 1) : 64'hBAD0_BAD0;
      tick();
      if (c == 10) check("gap_count_6",   64'(lane_count),  64'd6);
      if (c == 11) check("gap_count_hold", 64'(lane_count), 64'd6);
      if (c == 47) check("gap_valid_pre", 64'(state_valid), 64'd0);
    end
    lane_valid = 1'b0;
    check("gap_valid", 64'(state_valid), 64'd1);
    check("gap_count", 64'(lane_count),  64'd25);
    check_lanes("gap", 64'd1, 64'd1);
    release_state();

    // Clear mid-collect: the lane offered with clear is dropped
    for (int i = 0; i < 10; i++) begin
      lane_valid = 1'b1;
      lane_in    = 64'(100 + i);
      tick();
    end
    check("clr_count_10", 64'(lane_count), 64'd10);
    clear   = 1'b1;
    lane_in = 64'd777;
    tick();
    clear      = 1'b0;
    lane_valid = 1'b0;
    check("clr_count", 64'(lane_count), 64'd0);
    check("clr_zero",  64'(|state_out), 64'd0);
    check("clr_ready", 64'(lane_ready), 64'd1);
    fill(64'hA5A5_A5A5_A5A5_A5A5, 64'd0);
    check("a5_valid", 64'(state_valid), 64'd1);
    check_lanes("a5", 64'hA5A5_A5A5_A5A5_A5A5, 64'd0);

    // Clear in FULL together with state_ready behaves like a plain clear
    clear       = 1'b1;
    state_ready = 1'b1;
    tick();
    clear       = 1'b0;
    state_ready = 1'b0;
    check("clrfull_valid", 64'(state_valid), 64'd0);
    check("clrfull_zero",  64'(|state_out),  64'd0);

    // Reset mid-collect: outputs return immediately, off the clock edge
    for (int i = 0; i < 7; i++) begin
      lane_valid = 1'b1;
      lane_in    = 64'(50 + i);
      tick();
    end
    lane_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_count", 64'(lane_count),  64'd0);
    check("arst_ready", 64'(lane_ready),  64'd1);
    check("arst_valid", 64'(state_valid), 64'd0);
    check("arst_zero",  64'(|state_out),  64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Back-to-back with state_ready held high: two states, 26 cycles apart
    state_ready      = 1'b1;
    idx              = 0;
    n_valid          = 0;
    first_valid_cyc  = -1;
    second_valid_cyc = -1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      rdy_before = lane_ready;
      lane_valid = (idx < 2 * LANES);
      sent       = (idx < LANES) ? 64'(1000 + idx) : 64'(2000 + idx - LANES);
      lane_in    = sent;
      tick();
      if (lane_valid && rdy_before) idx++;
      if (state_valid) begin
        n_valid++;
        if (n_valid == 1) begin
          first_valid_cyc = cyc;
          check_lanes("b2b_a", 64'd1000, 64'd1);
        end else if (n_valid == 2) begin
          second_valid_cyc = cyc;
          check_lanes("b2b_b", 64'd2000, 64'd1);
        end
      end
    end
    lane_valid  = 1'b0;
    state_ready = 1'b0;
    check("b2b_first_cyc", 64'(first_valid_cyc),  64'd25);
    check("b2b_period",    64'(second_valid_cyc - first_valid_cyc), 64'd26);
    check("b2b_n_valid",   64'(n_valid), 64'd2);
    check("b2b_end_ready", 64'(lane_ready), 64'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
